serial_operand_feeder: RTL and testbench

- Upstream stage of the serial adder: accepts two WIDTH-bit parallel operands plus carry-in through a valid/ready handshake.
- Streams the operand bit pairs LSB-first, one pair per cycle, into the serial adder's bit inputs.
- Pulses a clear strobe before each new operand, so the adder re-latches carry-in on bit 0.
- Marks the first and last bits and signals completion, so the downstream collector can frame the sum word.

---
 rtl/serial_pkg.sv | 35 +++
 rtl/serial_operand_feeder_if.sv | 48 ++++
 rtl/serial_shreg.sv | 42 ++++
 rtl/serial_operand_feeder.sv | 122 ++++++++++++
 tb/tb_serial_operand_feeder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial adder datapath slice.
//   feed_state_t  - sequencing states of the operand feeder
//   DEFAULT_WIDTH - default operand length in bits
//   cw_of()       - width of a field that must hold 0..width inclusive
//   clamp_len()   - maps a requested bit count onto 1..width; zero or an
//                   oversize request means "use the full width". The
//                   downstream collector applies the same rule, so both ends
//                   always agree on the framed word length.
// -----------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cw_of(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned width);
    if ((len == 0) || (len > width)) begin
      return width;
    end
    return len;
  endfunction

endpackage

// File: rtl/serial_operand_feeder_if.sv
// -----------------------------------------------------------------------------
// serial_operand_feeder_if
// Bundles the operand handshake, the serial bit stream and its framing
// strobes into one interface.
//   master modport : producer / stream consumer side (drives in_valid, op_a,
//                    op_b, op_cin, op_len, ser_hold)
//   slave modport  : the feeder itself (drives in_ready, adder_clr,
//                    ser_valid, ser_a, ser_b, ser_cin, ser_first, ser_last,
//                    bit_idx, done)
// -----------------------------------------------------------------------------
interface serial_operand_feeder_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cw_of(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [CW-1:0]    op_len;

  logic             adder_clr;
  logic             ser_valid;
  logic             ser_a;
  logic             ser_b;
  logic             ser_cin;
  logic             ser_first;
  logic             ser_last;
  logic [CW-1:0]    bit_idx;
  logic             ser_hold;
  logic             done;

  modport master (
    output in_valid, op_a, op_b, op_cin, op_len, ser_hold,
    input  in_ready, adder_clr, ser_valid, ser_a, ser_b, ser_cin,
           ser_first, ser_last, bit_idx, done
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, op_len, ser_hold,
    output in_ready, adder_clr, ser_valid, ser_a, ser_b, ser_cin,
           ser_first, ser_last, bit_idx, done
  );

endinterface

// File: rtl/serial_shreg.sv
// -----------------------------------------------------------------------------
// serial_shreg
// WIDTH-bit parallel-load, shift-right register with zero fill. Only the
// LSB leaves the block because that is the bit currently on the wire.
// Ports:
//   clk      in  rising-edge clock
//   reset    in  asynchronous active-low reset (clears the register)
//   load     in  capture d (takes priority over shift_en)
//   shift_en in  shift right by one, 0 enters at the MSB
//   d        in  WIDTH parallel load value
//   lsb      out current bit 0 of the register
// -----------------------------------------------------------------------------
module serial_shreg
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             lsb
);

  logic [WIDTH-1:0] q;

  // Load wins over shift so a new operand is never corrupted by a stale
  // shift request in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// -----------------------------------------------------------------------------
// serial_operand_feeder
// Accepts an operand set (A, B, carry-in, length) over a valid/ready
// handshake and streams the bit pairs LSB-first into the serial adder.
// Sequence per operand: one CLEAR cycle (adder_clr) so the adder re-latches
// carry-in, len SHIFT cycles presenting one bit each, one DONE cycle (done).
// ser_hold freezes the stream while in SHIFT.
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous active-low reset; aborts any transfer in flight
//   bus   slave modport of serial_operand_feeder_if
//         (in_valid/in_ready/op_a/op_b/op_cin/op_len handshake,
//          adder_clr, ser_valid/ser_a/ser_b/ser_cin/ser_first/ser_last,
//          bit_idx, ser_hold, done)
// Every output is decoded from registered state only, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cw_of(WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_operand_feeder_if.slave  bus
);

  feed_state_t   state;
  logic [CW-1:0] counter;
  logic [CW-1:0] len_reg;
  logic          cin_reg;

  logic          accept;
  logic          in_shift;
  logic          shift_step;
  logic          is_first;
  logic          is_last;
  logic [CW-1:0] last_idx;
  logic          a_lsb;
  logic          b_lsb;

  assign accept     = (state == IDLE) && bus.in_valid;
  assign in_shift   = (state == SHIFT);
  assign shift_step = in_shift && !bus.ser_hold;
  assign last_idx   = len_reg - CW'(1);
  assign is_first   = in_shift && (counter == '0);
  assign is_last    = in_shift && (counter == last_idx);

  serial_shreg #(.WIDTH(WIDTH)) u_shreg_a (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift_en (shift_step),
    .d        (bus.op_a),
    .lsb      (a_lsb)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_shreg_b (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift_en (shift_step),
    .d        (bus.op_b),
    .lsb      (b_lsb)
  );

  // Sequencer. The length is clamped once at accept time so the SHIFT
  // comparison never has to deal with 0 or oversize requests. On the last
  // bit the counter is left alone and the FSM moves straight to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      len_reg <= '0;
      cin_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            len_reg <= CW'(clamp_len(int'(bus.op_len), WIDTH));
            cin_reg <= bus.op_cin;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          counter <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (!bus.ser_hold) begin
            if (is_last) begin
              state <= DONE;
            end else begin
              counter <= counter + CW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode. Stream fields are forced low outside SHIFT so the
  // downstream collector only ever sees meaningful bits.
  assign bus.in_ready  = (state == IDLE);
  assign bus.adder_clr = (state == CLEAR);
  assign bus.ser_valid = in_shift;
  assign bus.ser_a     = in_shift & a_lsb;
  assign bus.ser_b     = in_shift & b_lsb;
  assign bus.ser_first = is_first;
  assign bus.ser_last  = is_last;
  assign bus.ser_cin   = cin_reg & is_first;
  assign bus.bit_idx   = in_shift ? counter : '0;
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_serial_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_operand_feeder
// Self-checking bench for serial_operand_feeder (WIDTH = 8).
// -----------------------------------------------------------------------------
module tb_serial_operand_feeder;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  typedef struct packed {
    logic          in_ready;
    logic          adder_clr;
    logic          ser_valid;
    logic          ser_a;
    logic          ser_b;
    logic          ser_cin;
    logic          ser_first;
    logic          ser_last;
    logic [CW-1:0] bit_idx;
    logic          done;
  } obs_t;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [3:0] op_len;
    int         hold_bit;
    int         hold_cycles;
    bit         pulse_valid;
    int         exp_len;
    int         exp_done;
  } vec_t;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic reset  = 1'b1;

  int checks   = 0;
  int failures = 0;

  always #5 if (clk_en) clk = ~clk;

  serial_operand_feeder_if #(.WIDTH(WIDTH)) bus ();

  serial_operand_feeder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Snapshot of every DUT output in one packed record
  function automatic obs_t sample_obs();
    obs_t o;
    o.in_ready  = bus.in_ready;
    o.adder_clr = bus.adder_clr;
    o.ser_valid = bus.ser_valid;
    o.ser_a     = bus.ser_a;
    o.ser_b     = bus.ser_b;
    o.ser_cin   = bus.ser_cin;
    o.ser_first = bus.ser_first;
    o.ser_last  = bus.ser_last;
    o.bit_idx   = bus.bit_idx;
    o.done      = bus.done;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o          = '0;
    o.in_ready = 1'b1;
    return o;
  endfunction

  // Reference length rule: zero or oversize means full width
  function automatic int model_len(input logic [3:0] op_len);
    if ((op_len == 0) || (op_len > WIDTH)) return WIDTH;
    return int'(op_len);
  endfunction

  // Compare all outputs; data bits and index are don't-care when no bit is
  // live unless strict is set (reset values are fully defined).
  task automatic checkOutput(input string name, input obs_t exp, input bit strict);
    obs_t got;
    obs_t m;
    got = sample_obs();
    m   = '1;
    if (!strict && !exp.ser_valid) begin
      m.ser_a   = 1'b0;
      m.ser_b   = 1'b0;
      m.bit_idx = '0;
    end
    checks++;
    if ((got & m) !== (exp & m)) begin
      failures++;
      $display("[TB] FAIL %s got=%b required=%b (rdy clr vld a b cin first last idx done)",
               name, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // One complete transfer starting at a negedge with the DUT idle. The
  // expected stream comes straight from the operands: bit k of A/B, carry
  // only on bit 0, first/last flags from k and the clamped length.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic [3:0] op_len, input int exp_len,
                               input int hold_bit, input int hold_cycles,
                               input bit pulse_valid, input int exp_done);
    obs_t       e;
    logic [7:0] got_a;
    logic [7:0] got_b;
    logic [7:0] mask;
    int         cyc;
    int         reps;
    bit         seen;
    got_a = '0;
    got_b = '0;
    mask  = (exp_len >= 8) ? 8'hFF : 8'((1 << exp_len) - 1);
    checkOutput({tag, ":idle"}, idle_obs(), 1'b0);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_cin   = cin;
    bus.op_len   = op_len;
    @(negedge clk);
    cyc          = 1;
    bus.in_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
    bus.op_cin   = ~cin;
    e            = '0;
    e.adder_clr  = 1'b1;
    checkOutput({tag, ":clear"}, e, 1'b0);
    for (int k = 0; k < exp_len; k++) begin
      reps = (k == hold_bit) ? hold_cycles + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        @(negedge clk);
        cyc++;
        e           = '0;
        e.ser_valid = 1'b1;
        e.ser_a     = a[k];
        e.ser_b     = b[k];
        e.ser_cin   = cin && (k == 0);
        e.ser_first = (k == 0);
        e.ser_last  = (k == exp_len - 1);
        e.bit_idx   = CW'(k);
        checkOutput($sformatf("%s:bit%0d", tag, k), e, 1'b0);
        if (bus.ser_valid && (int'(bus.bit_idx) < 8)) begin
          got_a[bus.bit_idx[2:0]] = bus.ser_a;
          got_b[bus.bit_idx[2:0]] = bus.ser_b;
        end
        bus.ser_hold = (r < reps - 1);
        if (pulse_valid) begin
          bus.in_valid = 1'b1;
          bus.op_a     = 8'($urandom);
          bus.op_b     = 8'($urandom);
          bus.op_len   = 4'($urandom_range(1, 3));
        end
      end
    end
    bus.ser_hold = 1'b0;
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int w = 0; (w < 4) && !seen; w++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1'b1;
      else if (bus.ser_valid && (int'(bus.bit_idx) < 8)) begin
        got_a[bus.bit_idx[2:0]] = bus.ser_a;
        got_b[bus.bit_idx[2:0]] = bus.ser_b;
      end
    end
    if (!seen) begin
      checkValue({tag, ":done_timeout"}, 0, 1);
    end else begin
      checkValue({tag, ":done_cycle"}, cyc, exp_done);
      e      = '0;
      e.done = 1'b1;
      checkOutput({tag, ":done"}, e, 1'b0);
    end
    checkValue({tag, ":word_a"}, int'(got_a), int'(a & mask));
    checkValue({tag, ":word_b"}, int'(got_b), int'(b & mask));
    @(negedge clk);
    checkOutput({tag, ":ready_again"}, idle_obs(), 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    int       done_seen;
    bit       found;
    logic [7:0] ra;
    logic [7:0] rb;
    logic     rc;
    logic [3:0] rl;
    int       len;
    int       hb;
    int       hc;

    vecs[0] = '{"full",      8'h0B, 8'h06, 1'b1, 4'd0,  -1, 0, 1'b0, 8, 10};
    vecs[1] = '{"short3",    8'hFF, 8'h01, 1'b0, 4'd3,  -1, 0, 1'b0, 3, 5};
    vecs[2] = '{"stall",     8'h0B, 8'h06, 1'b1, 4'd0,   2, 2, 1'b0, 8, 12};
    vecs[3] = '{"len1",      8'hA5, 8'h3C, 1'b1, 4'd1,  -1, 0, 1'b0, 1, 3};
    vecs[4] = '{"len12",     8'h5A, 8'hC3, 1'b0, 4'd12, -1, 0, 1'b0, 8, 10};
    vecs[5] = '{"pulse",     8'h96, 8'h69, 1'b1, 4'd0,  -1, 0, 1'b1, 8, 10};
    vecs[6] = '{"len8",      8'h80, 8'h7F, 1'b1, 4'd8,   7, 1, 1'b0, 8, 11};
    vecs[7] = '{"len2hold",  8'h01, 8'hFE, 1'b0, 4'd2,   1, 1, 1'b0, 2, 5};

    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.op_cin   = 1'b0;
    bus.op_len   = '0;
    bus.ser_hold = 1'b0;

    // Reset with the clock stopped: outputs must settle without any edge
    #3 reset = 1'b0;
    #2;
    checkOutput("reset_async_noclk", idle_obs(), 1'b1);
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_held", idle_obs(), 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_released", idle_obs(), 1'b1);

    // Directed vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op_len,
                    vecs[i].exp_len, vecs[i].hold_bit, vecs[i].hold_cycles,
                    vecs[i].pulse_valid, vecs[i].exp_done);
    end

    // Abort during bit 4, then recover
    bus.in_valid = 1'b1;
    bus.op_a     = 8'hC7;
    bus.op_b     = 8'h3A;
    bus.op_cin   = 1'b1;
    bus.op_len   = 4'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    found = 1'b0;
    for (int w = 0; (w < 12) && !found; w++) begin
      @(negedge clk);
      if (bus.ser_valid && (bus.bit_idx == 4'd4)) found = 1'b1;
    end
    checkValue("abort_reach_bit4", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_immediate", idle_obs(), 1'b1);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    checkValue("abort_no_done", done_seen, 0);
    applyStimulus("recover", 8'h5C, 8'hA3, 1'b0, 4'd5, 5, -1, 0, 1'b0, 7);

    // Randomized transfers against the length/bit model
    for (int n = 0; n < 40; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom);
      rl  = 4'($urandom_range(0, 15));
      len = model_len(rl);
      hb  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      hc  = (hb >= 0) ? $urandom_range(1, 3) : 0;
      applyStimulus($sformatf("rand%0d", n), ra, rb, rc, rl, len, hb, hc,
                    1'($urandom_range(0, 1)), 2 + len + hc);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule
